// File: rtl/zkbdmus_evq.sv
// zkbdmus_evq: key matrix, mouse channels and Kempston byte as seen by zports,
// plus a scanner that turns matrix changes into a press/release event FIFO.
module zkbdmus_evq #(
  parameter  int ROWS   = 8,
  parameter  int COLS   = 5,
  parameter  int MUS_CH = 3,
  parameter  int DEPTH  = 16,
  localparam int N      = ROWS * COLS,
  localparam int SW     = (MUS_CH > 1) ? $clog2(MUS_CH) : 1,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic [N-1:0]      kbd_in,
  input  logic              kbd_stb,
  input  logic [7:0]        mus_in,
  input  logic [MUS_CH-1:0] mus_stb,
  input  logic              kj_stb,
  input  logic [ROWS-1:0]   zah,
  input  logic [SW-1:0]     mus_sel,
  output logic [COLS-1:0]   kbd_data,
  output logic [7:0]        mus_data,
  output logic [4:0]        kj_data,
  output logic [7:0]        evt_data,
  output logic              evt_valid,
  input  logic              evt_pop,
  input  logic              evt_clr,
  output logic              evt_ovf,
  output logic [CW-1:0]     evt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]             kbd_q, kbd_d;
  logic [N-1:0]             ref_q, ref_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic [MUS_CH-1:0][7:0]   mus_q;
  logic [4:0]               kj_q;
  logic [7:0]               mem_q [DEPTH];

  logic                     cur, diff, full, pop, push;
  logic [6:0]               idx7;

  // Scanner view of the key under idx: current state versus last reported state.
  assign cur  = kbd_q[idx_q];
  assign diff = cur ^ ref_q[idx_q];
  assign idx7 = 7'(idx_q);
  assign full = (cnt_q == CW'(DEPTH));
  assign pop  = evt_pop && (cnt_q != '0);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push = diff && (!full || pop) && !evt_clr;

  // Next-state for matrix, reference, scan index, FIFO pointers and overflow flag.
  always_comb begin
    kbd_d = kbd_stb ? kbd_in : kbd_q;
    ref_d = ref_q;
    idx_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (evt_clr) begin
      // Resync against the matrix as it will be after this edge so held keys stay silent.
      ref_d = kbd_d;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) begin
        ref_d[idx_q] = cur;
        wr_d         = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      // Deferred event: reference left alone so the next lap retries it.
      if (diff && full && !pop) ovf_d = 1'b1;
    end
  end

  // State registers for the scanner, FIFO control, mouse channels and joystick.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      kbd_q <= '0;
      ref_q <= '0;
      idx_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mus_q <= '1;
      kj_q  <= '0;
    end else begin
      kbd_q <= kbd_d;
      ref_q <= ref_d;
      idx_q <= idx_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      for (int ch = 0; ch < MUS_CH; ch++)
        if (mus_stb[ch]) mus_q[ch] <= mus_in;
      if (kj_stb) kj_q <= mus_in[4:0];
    end
  end

  // Event storage; contents are don't-care until written, so no reset.
  always_ff @(posedge fclk) begin
    if (push) mem_q[wr_q] <= {cur, idx7};
  end

  // Matrix read: a column reads 0 if any selected row has that key pressed.
  always_comb begin
    kbd_data = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!zah[r] && kbd_q[r + ROWS * (COLS - 1 - c)]) kbd_data[c] = 1'b0;
  end

  // Mouse channel select; unpopulated selects read as idle bus.
  always_comb begin
    mus_data = 8'hFF;
    for (int ch = 0; ch < MUS_CH; ch++)
      if (int'(mus_sel) == ch) mus_data = mus_q[ch];
  end

  assign kj_data   = kj_q;
  assign evt_valid = (cnt_q != '0);
  assign evt_data  = evt_valid ? mem_q[rd_q] : 8'h00;
  assign evt_ovf   = ovf_q;
  assign evt_cnt   = cnt_q;

endmodule

// File: tb/tb_zkbdmus_evq.sv
// Bench for zkbdmus_evq: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_zkbdmus_evq;

  localparam int ROWS = 8, COLS = 5, MUS_CH = 3, DEPTH = 16;
  localparam int N = ROWS * COLS;

  logic          fclk, rst;
  logic [N-1:0]  kbd_in;
  logic          kbd_stb;
  logic [7:0]    mus_in;
  logic [2:0]    mus_stb;
  logic          kj_stb;
  logic [7:0]    zah;
  logic [1:0]    mus_sel;
  logic [4:0]    kbd_data;
  logic [7:0]    mus_data;
  logic [4:0]    kj_data;
  logic [7:0]    evt_data;
  logic          evt_valid;
  logic          evt_pop, evt_clr;
  logic          evt_ovf;
  logic [4:0]    evt_cnt;

  zkbdmus_evq #(.ROWS(ROWS), .COLS(COLS), .MUS_CH(MUS_CH), .DEPTH(DEPTH)) dut (
    .fclk(fclk), .rst(rst), .kbd_in(kbd_in), .kbd_stb(kbd_stb), .mus_in(mus_in),
    .mus_stb(mus_stb), .kj_stb(kj_stb), .zah(zah), .mus_sel(mus_sel),
    .kbd_data(kbd_data), .mus_data(mus_data), .kj_data(kj_data), .evt_data(evt_data),
    .evt_valid(evt_valid), .evt_pop(evt_pop), .evt_clr(evt_clr), .evt_ovf(evt_ovf),
    .evt_cnt(evt_cnt)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_kbd, m_ref, m_nk;
  int           m_idx;
  logic [7:0]   m_q[$];
  logic         m_ovf;
  logic [7:0]   m_mus [MUS_CH];
  logic [4:0]   m_kj;
  logic         m_d;

  // Advance the model by one clock using the inputs present at the edge.
  always @(posedge fclk or posedge rst) begin
    if (rst) begin
      m_kbd = '0; m_ref = '0; m_idx = 0; m_q.delete(); m_ovf = 1'b0; m_kj = '0;
      for (int i = 0; i < MUS_CH; i++) m_mus[i] = 8'hFF;
    end else begin
      m_nk = kbd_stb ? kbd_in : m_kbd;
      m_d  = m_kbd[m_idx] ^ m_ref[m_idx];
      if (evt_clr) begin
        m_q.delete(); m_ovf = 1'b0; m_ref = m_nk;
      end else begin
        if (evt_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (m_d) begin
          if (m_q.size() < DEPTH) begin
            m_q.push_back({m_kbd[m_idx], 7'(m_idx)});
            m_ref[m_idx] = m_kbd[m_idx];
          end else m_ovf = 1'b1;
        end
      end
      m_kbd = m_nk;
      for (int i = 0; i < MUS_CH; i++) if (mus_stb[i]) m_mus[i] = mus_in;
      if (kj_stb) m_kj = mus_in[4:0];
      m_idx = (m_idx + 1) % N;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge fclk) begin
    logic [4:0] ek;
    logic [7:0] em;
    ek = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!zah[r] && m_kbd[r + ROWS * (COLS - 1 - c)]) ek[c] = 1'b0;
    em = (mus_sel < MUS_CH) ? m_mus[mus_sel] : 8'hFF;
    chk("kbd_data", 64'(kbd_data), 64'(ek));
    chk("mus_data", 64'(mus_data), 64'(em));
    chk("kj_data", 64'(kj_data), 64'(m_kj));
    chk("evt_valid", 64'(evt_valid), 64'(m_q.size() != 0));
    chk("evt_data", 64'(evt_data), 64'((m_q.size() != 0) ? m_q[0] : 8'h00));
    chk("evt_cnt", 64'(evt_cnt), 64'(m_q.size()));
    chk("evt_ovf", 64'(evt_ovf), 64'(m_ovf));
  end

  // Record popped events while collecting (the head seen here leaves at the next edge).
  logic         collect = 1'b0;
  logic [N-1:0] seen;
  int           npress, nother;
  always @(negedge fclk) begin
    if (collect && !rst && evt_pop && evt_valid && !evt_clr) begin
      if (evt_data[7] && int'(evt_data[6:0]) < N && !seen[evt_data[6:0]]) begin
        seen[evt_data[6:0]] = 1'b1; npress++;
      end else nother++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge fclk); #2; end
  endtask

  logic [N-1:0] pat;
  logic [7:0]   exp_head;
  int           k;

  initial begin
    rst = 1'b1; kbd_in = '0; kbd_stb = 0; mus_in = 0; mus_stb = 0; kj_stb = 0;
    zah = 8'hFE; mus_sel = 0; evt_pop = 0; evt_clr = 0;
    seen = '0; npress = 0; nother = 0;
    cyc(2);
    chk("rst_kbd_data", 64'(kbd_data), 64'h1F);
    chk("rst_evt_valid", 64'(evt_valid), 64'h0);
    chk("rst_evt_data", 64'(evt_data), 64'h00);
    rst = 1'b0;

    // 1: press CS (key 32)
    kbd_in = '0; kbd_in[32] = 1'b1; kbd_stb = 1; cyc(); kbd_stb = 0;
    chk("cs_kbd_data", 64'(kbd_data), 64'h1E);
    k = 0; while (!evt_valid && k < 40) begin cyc(); k++; end
    chk("cs_press_wait", 64'(evt_valid), 64'h1);
    chk("cs_press_data", 64'(evt_data), 64'hA0);
    chk("cs_press_cnt", 64'(evt_cnt), 64'h1);

    // 2: release CS, pop the press, expect the release
    kbd_in = '0; kbd_stb = 1; evt_pop = 1; cyc(); kbd_stb = 0; evt_pop = 0;
    k = 0; while (!evt_valid && k < 41) begin cyc(); k++; end
    chk("cs_release_data", 64'(evt_data), 64'h20);
    evt_pop = 1; cyc(); evt_pop = 0;
    chk("drain_valid", 64'(evt_valid), 64'h0);
    chk("drain_data", 64'(evt_data), 64'h00);

    // 3: all keys pressed, no pops -> FIFO fills and overflow sticks
    kbd_in = '1; kbd_stb = 1; cyc(); kbd_stb = 0;
    cyc(60);
    chk("full_cnt", 64'(evt_cnt), 64'd16);
    chk("full_ovf", 64'(evt_ovf), 64'h1);

    // 4: pop exactly when the scanner has a pending key -> count holds, head advances
    collect = 1'b1;
    k = 0;
    while (!(m_kbd[m_idx] ^ m_ref[m_idx]) && k < 100) begin cyc(); k++; end
    chk("pend_found", 64'(k < 100), 64'h1);
    exp_head = m_q[1];
    evt_pop = 1; cyc(); evt_pop = 0;
    chk("fullpp_cnt", 64'(evt_cnt), 64'd16);
    chk("fullpp_head", 64'(evt_data), 64'(exp_head));

    // 3 (cont.): pop continuously, every key reported exactly once
    evt_pop = 1; cyc(300); evt_pop = 0; cyc();
    collect = 1'b0;
    chk("press_total", 64'(npress), 64'd40);
    chk("press_other", 64'(nother), 64'd0);
    chk("press_seen", 64'(seen), 64'hFF_FFFF_FFFF);
    chk("ovf_sticky", 64'(evt_ovf), 64'h1);

    // 5: release everything, let events queue, then clear; held state goes silent
    kbd_in = '0; kbd_stb = 1; cyc(); kbd_stb = 0; cyc(20);
    kbd_in = 40'h00_F0F0_0F0F; kbd_stb = 1; evt_clr = 1; cyc(); kbd_stb = 0; evt_clr = 0;
    chk("clr_cnt", 64'(evt_cnt), 64'h0);
    chk("clr_ovf", 64'(evt_ovf), 64'h0);
    k = 0; repeat (80) begin if (evt_valid) k++; cyc(); end
    chk("clr_quiet", 64'(k), 64'h0);

    // 6: mouse and joystick
    mus_in = 8'h5A; mus_stb = 3'b110; cyc(); mus_stb = 0;
    mus_sel = 1; #1 chk("mus_ch1", 64'(mus_data), 64'h5A);
    mus_sel = 2; #1 chk("mus_ch2", 64'(mus_data), 64'h5A);
    mus_sel = 0; #1 chk("mus_ch0", 64'(mus_data), 64'hFF);
    mus_sel = 3; #1 chk("mus_ch3", 64'(mus_data), 64'hFF);
    mus_in = 8'hF3; kj_stb = 1; cyc(); kj_stb = 0;
    chk("kj_load", 64'(kj_data), 64'h13);

    // Randomized traffic
    pat = kbd_in;
    repeat (3000) begin
      kbd_stb = ($urandom_range(0, 7) == 0);
      if (kbd_stb) begin
        repeat ($urandom_range(1, 3)) pat[$urandom_range(0, N - 1)] ^= 1'b1;
        kbd_in = pat;
      end
      evt_pop = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      evt_clr = ($urandom_range(0, 199) == 0);
      mus_in  = 8'($urandom);
      mus_stb = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      kj_stb  = ($urandom_range(0, 9) == 0);
      zah     = 8'($urandom) | (($urandom_range(0, 1) == 1) ? 8'h00 : 8'hF0);
      mus_sel = 2'($urandom);
      cyc();
    end
    kbd_stb = 0; evt_pop = 0; evt_clr = 0; mus_stb = 0; kj_stb = 0;

    // Reset mid-scan with queued events
    zah = 8'h00; kbd_in = '1; kbd_stb = 1; cyc(); kbd_stb = 0; cyc(10);
    @(posedge fclk); #2 rst = 1'b1; #1;
    chk("mrst_kbd_data", 64'(kbd_data), 64'h1F);
    chk("mrst_valid", 64'(evt_valid), 64'h0);
    chk("mrst_data", 64'(evt_data), 64'h00);
    chk("mrst_cnt", 64'(evt_cnt), 64'h0);
    chk("mrst_ovf", 64'(evt_ovf), 64'h0);
    chk("mrst_kj", 64'(kj_data), 64'h0);
    mus_sel = 1; #1 chk("mrst_mus", 64'(mus_data), 64'hFF);
    cyc(2); rst = 1'b0; cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
